rx_anc_integrate_dump: RTL and testbench

- Sits directly downstream of the ANC receive frequency-shift/scale/clip stage.
- Consumes its 16-bit I/Q AXI-stream and coherently integrates nsum consecutive samples per window, one window per tone-dwell period.
- Emits one wide accumulated I/Q result per window, plus the sample count, as an AXI-stream for host readout or a correlation stage.
- Buffers one finished result and applies backpressure upstream only when that buffer is occupied.

---
 rtl/rx_anc_pkg.sv | 23 ++
 rtl/rx_anc_acc_rail.sv | 64 ++++++
 rtl/rx_anc_integrate_dump.sv | 199 +++++++++++++++++++
 tb/tb_rx_anc_integrate_dump.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_anc_pkg.sv
`default_nettype none
// ============================================================================
// Module : rx_anc_pkg
// Brief  : Shared types and helpers for the ANC receive integrate-and-dump.
//          The result record is declared inside the top module because its
//          field widths follow that instance's parameters.
// Rev    : 1.0  initial release
// ============================================================================
package rx_anc_pkg;

  // Top-level control state: accepting samples, or stalled with a parked result
  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  // Window length from the nsum control; zero still means one sample per window
  function automatic logic [31:0] nsum_to_nlat(input logic [31:0] nsum_v);
    return (nsum_v == 32'd0) ? 32'd1 : nsum_v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_anc_acc_rail.sv
`default_nettype none
// ============================================================================
// Module : rx_anc_acc_rail
// Brief  : One rail of the integrator. Sign-extends the sample, loads it on
//          the first beat of a window and accumulates (wrapping) afterwards.
//          sum_o is the combinational running sum including the current beat.
//          With RX_ANC_ID_OVF_DETECT_EN defined, ovf_o flags a two's
//          complement overflow of the current accumulate.
// Rev    : 1.0  initial release
// ============================================================================
module rx_anc_acc_rail #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  srst,
  input  logic                  en_i,
  input  logic                  first_i,
  input  logic                  dump_i,
  input  logic [DATA_WIDTH-1:0] din_i,
`ifdef RX_ANC_ID_OVF_DETECT_EN
  output logic                  ovf_o,
`endif
  output logic [ACC_WIDTH-1:0]  sum_o
);

  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] acc_d;
  logic [ACC_WIDTH-1:0] din_ext;

  assign din_ext = {{(ACC_WIDTH-DATA_WIDTH){din_i[DATA_WIDTH-1]}}, din_i};

  // First beat of a window replaces the stale sum instead of adding to it
  assign sum_o = first_i ? din_ext : (acc_q + din_ext);

`ifdef RX_ANC_ID_OVF_DETECT_EN
  // Overflow only exists on a real add: equal operand signs, different result sign
  assign ovf_o = en_i && !first_i &&
                 (acc_q[ACC_WIDTH-1] == din_ext[ACC_WIDTH-1]) &&
                 (sum_o[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
`endif

  // Next accumulator: running sum, or back to zero once the window is dumped
  always_comb begin
    acc_d = acc_q;
    if (en_i) begin
      acc_d = dump_i ? '0 : sum_o;
    end
  end

  // Accumulator register with async and sync clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else if (srst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rx_anc_integrate_dump.sv
`default_nettype none
// ============================================================================
// Module : rx_anc_integrate_dump
// Brief  : Coherent I/Q integrate-and-dump over nsum samples (or up to
//          in_tlast). One result register plus one hold register; upstream
//          is stalled only while the hold register is occupied.
//          Optional macro RX_ANC_ID_OVF_DETECT_EN adds a sticky overflow
//          flag (ovf) with clear input (ovf_clr).
// Rev    : 1.0  initial release
// ============================================================================
module rx_anc_integrate_dump
  import rx_anc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int NSUM_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  srst,
  input  logic [NSUM_WIDTH-1:0] nsum,
  input  logic [DATA_WIDTH-1:0] in_i,
  input  logic [DATA_WIDTH-1:0] in_q,
  input  logic                  in_tvalid,
  input  logic                  in_tlast,
  output logic                  in_tready,
  output logic [ACC_WIDTH-1:0]  out_i,
  output logic [ACC_WIDTH-1:0]  out_q,
  output logic [NSUM_WIDTH-1:0] out_cnt,
  output logic                  out_tlast,
  output logic                  out_tvalid,
`ifdef RX_ANC_ID_OVF_DETECT_EN
  output logic                  ovf,
  input  logic                  ovf_clr,
`endif
  input  logic                  out_tready
);

  typedef struct packed {
    logic [ACC_WIDTH-1:0]  i;
    logic [ACC_WIDTH-1:0]  q;
    logic [NSUM_WIDTH-1:0] cnt;
    logic                  last;
  } res_t;

  state_t                state_q, state_d;
  logic [NSUM_WIDTH-1:0] cnt_q, cnt_d;
  logic [NSUM_WIDTH-1:0] nlat_q, nlat_d;
  res_t                  out_q_r, out_d_r;
  res_t                  hold_q, hold_d;
  logic                  outv_q, outv_d;

  logic                  in_fire;
  logic                  out_fire;
  logic                  first;
  logic                  win_end;
  logic [NSUM_WIDTH-1:0] nlat_new;
  logic [NSUM_WIDTH-1:0] nlat_cur;
  logic [NSUM_WIDTH-1:0] cnt_inc;
  logic [ACC_WIDTH-1:0]  sum_i;
  logic [ACC_WIDTH-1:0]  sum_q;
  res_t                  res;

  assign in_tready = (state_q == ST_ACCUM);
  assign in_fire   = in_tvalid && in_tready;
  assign out_fire  = outv_q && out_tready;
  assign first     = (cnt_q == '0);
  assign nlat_new  = NSUM_WIDTH'(nsum_to_nlat(32'(nsum)));
  // Window length is latched on the first beat; later nsum edits wait a window
  assign nlat_cur  = first ? nlat_new : nlat_q;
  assign cnt_inc   = cnt_q + 1'b1;
  assign win_end   = in_fire && ((cnt_inc == nlat_cur) || in_tlast);

  assign out_i      = out_q_r.i;
  assign out_q      = out_q_r.q;
  assign out_cnt    = out_q_r.cnt;
  assign out_tlast  = out_q_r.last;
  assign out_tvalid = outv_q;

`ifdef RX_ANC_ID_OVF_DETECT_EN
  logic ovf_rail_i, ovf_rail_q;
  logic ovf_q, ovf_d;
`endif

  rx_anc_acc_rail #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_rail_i (
    .clk     (clk),
    .reset   (reset),
    .srst    (srst),
    .en_i    (in_fire),
    .first_i (first),
    .dump_i  (win_end),
    .din_i   (in_i),
`ifdef RX_ANC_ID_OVF_DETECT_EN
    .ovf_o   (ovf_rail_i),
`endif
    .sum_o   (sum_i)
  );

  rx_anc_acc_rail #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_rail_q (
    .clk     (clk),
    .reset   (reset),
    .srst    (srst),
    .en_i    (in_fire),
    .first_i (first),
    .dump_i  (win_end),
    .din_i   (in_q),
`ifdef RX_ANC_ID_OVF_DETECT_EN
    .ovf_o   (ovf_rail_q),
`endif
    .sum_o   (sum_q)
  );

  // Counter, window length, output register and hold-register sequencing
  always_comb begin
    res      = '{i: sum_i, q: sum_q, cnt: cnt_inc, last: in_tlast};
    state_d  = state_q;
    cnt_d    = cnt_q;
    nlat_d   = nlat_q;
    out_d_r  = out_q_r;
    hold_d   = hold_q;
    outv_d   = outv_q;

    if (in_fire) begin
      cnt_d = win_end ? '0 : cnt_inc;
      if (first) begin
        nlat_d = nlat_new;
      end
    end

    if (win_end) begin
      // Output slot free (or emptying now): publish directly, else park it
      if (!outv_q || out_fire) begin
        out_d_r = res;
        outv_d  = 1'b1;
      end else begin
        hold_d  = res;
        state_d = ST_HOLD;
      end
    end else if ((state_q == ST_HOLD) && out_fire) begin
      out_d_r = hold_q;
      state_d = ST_ACCUM;
    end else if (out_fire) begin
      outv_d = 1'b0;
    end
  end

  // Control and data registers; async reset and sync clear discard everything
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_ACCUM;
      cnt_q   <= '0;
      nlat_q  <= '0;
      out_q_r <= '0;
      hold_q  <= '0;
      outv_q  <= 1'b0;
    end else if (srst) begin
      state_q <= ST_ACCUM;
      cnt_q   <= '0;
      nlat_q  <= '0;
      out_q_r <= '0;
      hold_q  <= '0;
      outv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nlat_q  <= nlat_d;
      out_q_r <= out_d_r;
      hold_q  <= hold_d;
      outv_q  <= outv_d;
    end
  end

`ifdef RX_ANC_ID_OVF_DETECT_EN
  // Sticky overflow: a new overflow wins over a same-cycle clear
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_rail_i || ovf_rail_q) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Overflow flag register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (srst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rx_anc_integrate_dump.sv
`default_nettype none
// ============================================================================
// Module : tb_rx_anc_integrate_dump
// Brief  : Directed self-checking bench for rx_anc_integrate_dump. Inputs
//          change on the falling edge; outputs are sampled on the falling edge.
// Rev    : 1.0  initial release
// ============================================================================
module tb_rx_anc_integrate_dump;

`ifdef RX_ANC_ID_OVF_DETECT_EN
  localparam int AW = 17;
`else
  localparam int AW = 32;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          srst = 1'b0;
  logic [15:0]   nsum = '0;
  logic [15:0]   in_i = '0;
  logic [15:0]   in_q = '0;
  logic          in_tvalid = 1'b0;
  logic          in_tlast = 1'b0;
  logic          in_tready;
  logic [AW-1:0] out_i;
  logic [AW-1:0] out_q;
  logic [15:0]   out_cnt;
  logic          out_tlast;
  logic          out_tvalid;
  logic          out_tready = 1'b0;
`ifdef RX_ANC_ID_OVF_DETECT_EN
  logic          ovf;
  logic          ovf_clr = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  rx_anc_integrate_dump #(.DATA_WIDTH(16), .ACC_WIDTH(AW), .NSUM_WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .srst       (srst),
    .nsum       (nsum),
    .in_i       (in_i),
    .in_q       (in_q),
    .in_tvalid  (in_tvalid),
    .in_tlast   (in_tlast),
    .in_tready  (in_tready),
    .out_i      (out_i),
    .out_q      (out_q),
    .out_cnt    (out_cnt),
    .out_tlast  (out_tlast),
    .out_tvalid (out_tvalid),
`ifdef RX_ANC_ID_OVF_DETECT_EN
    .ovf        (ovf),
    .ovf_clr    (ovf_clr),
`endif
    .out_tready (out_tready)
  );

  always #5 clk = ~clk;

  // Expected accumulator value of a signed integer, as an AW-bit pattern
  function automatic logic [63:0] acc(input int v);
    logic [AW-1:0] t;
    t = AW'(v);
    return 64'(t);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    // Reset state, checked while reset is still asserted
    #2;
    check("rst_valid", 64'(out_tvalid), 64'd0);
    check("rst_ready", 64'(in_tready), 64'd1);
    check("rst_out_i", 64'(out_i), 64'd0);
    check("rst_cnt",   64'(out_cnt), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Basic sum: nsum=4
    nsum = 16'd4;
    out_tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_i = 16'(k + 1);
      in_q = 16'(-(k + 1));
      in_tvalid = 1'b1;
      @(negedge clk);
      if (k < 3) check("t1_early_valid", 64'(out_tvalid), 64'd0);
    end
    check("t1_valid", 64'(out_tvalid), 64'd1);
    check("t1_i",     64'(out_i), acc(10));
    check("t1_q",     64'(out_q), acc(-10));
    check("t1_cnt",   64'(out_cnt), 64'd4);
    check("t1_last",  64'(out_tlast), 64'd0);
    in_tvalid = 1'b0;
    @(negedge clk);
    check("t1_drained", 64'(out_tvalid), 64'd0);

    // Backpressure: nsum=2, downstream stalled
    nsum = 16'd2;
    out_tready = 1'b0;
    in_i = 16'd100;
    for (int k = 0; k < 4; k++) begin
      in_q = (k < 2) ? 16'd1 : 16'd2;
      in_tvalid = 1'b1;
      @(negedge clk);
      if (k == 1) begin
        check("t2_first_valid", 64'(out_tvalid), 64'd1);
        check("t2_first_i",     64'(out_i), acc(200));
        check("t2_ready_mid",   64'(in_tready), 64'd1);
      end
    end
    check("t2_hold_ready", 64'(in_tready), 64'd0);
    check("t2_hold_q",     64'(out_q), acc(2));
    in_tvalid = 1'b0;
    @(negedge clk);
    check("t2_stable_i",   64'(out_i), acc(200));
    check("t2_stable_q",   64'(out_q), acc(2));
    check("t2_still_hold", 64'(in_tready), 64'd0);
    out_tready = 1'b1;
    @(negedge clk);
    check("t2_second_valid", 64'(out_tvalid), 64'd1);
    check("t2_second_i",     64'(out_i), acc(200));
    check("t2_second_q",     64'(out_q), acc(4));
    check("t2_second_cnt",   64'(out_cnt), 64'd2);
    check("t2_ready_back",   64'(in_tready), 64'd1);
    @(negedge clk);
    check("t2_drained", 64'(out_tvalid), 64'd0);

    // Early tlast, then a single-beat tlast window
    nsum = 16'd8;
    in_i = 16'd5;
    in_q = 16'd0;
    for (int k = 0; k < 3; k++) begin
      in_tlast = (k == 2);
      in_tvalid = 1'b1;
      @(negedge clk);
    end
    check("t3_valid", 64'(out_tvalid), 64'd1);
    check("t3_i",     64'(out_i), acc(15));
    check("t3_cnt",   64'(out_cnt), 64'd3);
    check("t3_last",  64'(out_tlast), 64'd1);
    in_i = 16'd7;
    in_tlast = 1'b1;
    @(negedge clk);
    check("t3b_i",    64'(out_i), acc(7));
    check("t3b_cnt",  64'(out_cnt), 64'd1);
    check("t3b_last", 64'(out_tlast), 64'd1);
    in_tvalid = 1'b0;
    in_tlast = 1'b0;
    @(negedge clk);

    // nsum=0 and nsum=1: one result per cycle at full negative scale
    in_i = 16'h8000;
    in_q = 16'd0;
    in_tvalid = 1'b1;
    for (int n = 0; n < 2; n++) begin
      nsum = 16'(n);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check("t4_valid", 64'(out_tvalid), 64'd1);
        check("t4_i",     64'(out_i), acc(-32768));
        check("t4_cnt",   64'(out_cnt), 64'd1);
        check("t4_ready", 64'(in_tready), 64'd1);
      end
    end
    in_tvalid = 1'b0;
    @(negedge clk);

    // Async reset with a waiting result and a half-filled window
    out_tready = 1'b0;
    nsum = 16'd1;
    in_i = 16'd3;
    in_tvalid = 1'b1;
    @(negedge clk);
    nsum = 16'd4;
    in_i = 16'd1;
    @(negedge clk);
    @(negedge clk);
    in_tvalid = 1'b0;
    check("t5_pre_valid", 64'(out_tvalid), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_valid", 64'(out_tvalid), 64'd0);
    check("t5_rst_i",     64'(out_i), 64'd0);
    check("t5_rst_cnt",   64'(out_cnt), 64'd0);
    check("t5_rst_ready", 64'(in_tready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    out_tready = 1'b1;
    in_tvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 2) check("t5_no_early", 64'(out_tvalid), 64'd0);
    end
    check("t5_i",   64'(out_i), acc(4));
    check("t5_cnt", 64'(out_cnt), 64'd4);
    in_tvalid = 1'b0;
    @(negedge clk);

    // Synchronous clear discards a partial window
    nsum = 16'd2;
    in_i = 16'd9;
    in_tvalid = 1'b1;
    @(negedge clk);
    in_tvalid = 1'b0;
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    in_i = 16'd3;
    in_tvalid = 1'b1;
    @(negedge clk);
    check("t6_no_early", 64'(out_tvalid), 64'd0);
    in_i = 16'd4;
    @(negedge clk);
    check("t6_i",   64'(out_i), acc(7));
    check("t6_cnt", 64'(out_cnt), 64'd2);
    in_tvalid = 1'b0;
    @(negedge clk);

`ifdef RX_ANC_ID_OVF_DETECT_EN
    // Overflow: 17-bit accumulator, 32767 x 4 first overflows on the 3rd beat
    check("t7_ovf_init", 64'(ovf), 64'd0);
    nsum = 16'd4;
    in_i = 16'd32767;
    in_q = 16'd0;
    in_tvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 1) check("t7_ovf_beat2", 64'(ovf), 64'd0);
      if (k == 2) check("t7_ovf_beat3", 64'(ovf), 64'd1);
    end
    check("t7_wrap_i", 64'(out_i), acc(-4));
    in_tvalid = 1'b0;
    @(negedge clk);
    check("t7_sticky", 64'(ovf), 64'd1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("t7_cleared", 64'(ovf), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Guard against a stuck run
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
